ones_seq_gen: RTL and testbench
===============================

ONES_SEQ_GEN -- requirements
Module: ones_seq_gen

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 7, meaning serial frame length in bits; only the value 7 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning a request count is offered.
REQ-005 The block SHALL have port in_count, input, 3, meaning the number of ones to emit (0..7).
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts a request this cycle.
REQ-007 The block SHALL have port bit_ready, input, 1, meaning downstream consumes bit_out this cycle.
REQ-008 The block SHALL have port bit_valid, output, 1, meaning bit_out carries a frame bit.
REQ-009 The block SHALL have port bit_out, output, 1, the serial frame bit.
REQ-010 The block SHALL have port out_word, output, 7, the parallel image of bits emitted so far (bit i = i-th emitted bit).
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse when a frame completes.
REQ-012 The block SHALL have port err, output, 1, a sticky self-check error flag.

Function
REQ-013 The FSM SHALL have three states: IDLE, SEND and DONE; all outputs SHALL be registered or decoded from registered state only (Moore).
REQ-014 In IDLE: in_ready=1, bit_valid=0; when in_valid=1 at a clk edge, in_count SHALL be latched, idx cleared to 0, out_word cleared to 0, and the state SHALL go to SEND.
REQ-015 In SEND: bit_valid=1, in_ready=0, bit_out=1 when idx<latched count, else 0 (thermometer, LSB first).
REQ-016 In SEND, on an edge with bit_ready=1: out_word[idx] SHALL take bit_out and idx SHALL increment; with bit_ready=0, idx, bit_out and out_word SHALL hold (stall of unbounded length).
REQ-017 The handshake on the last bit (idx=6 with bit_ready=1) SHALL move the state to DONE.
REQ-018 In DONE: done=1 for exactly one cycle, bit_valid=0, in_ready=0, out_word holds the full frame; the next state SHALL be IDLE.
REQ-019 With bit_ready held high, the latency SHALL be as follows: accept at edge k, bits valid in cycles k+1..k+7, done in cycle k+8, in_ready=1 again in cycle k+9.
REQ-020 in_valid and in_count SHALL be ignored outside IDLE; a request is never queued.
REQ-021 in_count=0 SHALL emit seven 0 bits; in_count=7 SHALL emit seven 1 bits; out_word after DONE SHALL contain exactly in_count ones.
REQ-022 out_word SHALL hold its value through DONE and IDLE until the next acceptance clears it.

Reset
REQ-023 reset=0 SHALL asynchronously force state=IDLE, idx=0, latched count=0, out_word=0, bit_valid=0, bit_out=0, done=0, err=0, and therefore in_ready=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no done pulse; the first edge after release SHALL behave as IDLE.

Configuration
REQ-025 When macro ONES_SEQ_GEN_CHECK_EN is defined: an internal 3-bit counter SHALL count handshaked 1-bits per frame (cleared on acceptance), and in DONE a mismatch with the latched count SHALL set err=1, sticky until reset.
REQ-026 When ONES_SEQ_GEN_CHECK_EN is undefined: the counter SHALL be absent, the err port SHALL remain and be tied to 0, and all other behaviour SHALL be identical.

Verification
REQ-027 The bench SHALL cover: reset, then in_count=3 accepted with bit_ready=1 -> bit_out sequence 1,1,1,0,0,0,0, done in cycle k+8, out_word=7'b0000111.
REQ-028 The bench SHALL cover: in_count=0, then in_count=7 back-to-back (in_valid held) -> out_word=7'b0000000 then 7'b1111111, second acceptance no earlier than cycle k+9.
REQ-029 The bench SHALL cover: in_count=5 with bit_ready=0 for 4 cycles after the 2nd bit -> bit_out=1 held, idx frozen, frame still 1,1,1,1,1,0,0, done delayed by 4 cycles.
REQ-030 The bench SHALL cover: in_valid pulsed with in_count=2 during SEND of an in_count=6 frame -> ignored, out_word=7'b0111111.
REQ-031 The bench SHALL cover: reset=0 after 3 bits of an in_count=4 frame -> immediate bit_valid=0, out_word=0, no done, in_ready=1.
REQ-032 The bench SHALL cover, with ONES_SEQ_GEN_CHECK_EN defined, all in_count 0..7 -> err stays 0; forcing the internal counter -> err=1 until reset.

Source files
------------

// File: rtl/ones_seq_gen.sv
// ones_seq_gen
//   Serial thermometer-frame generator. One request carries a count
//   (0..7); the block then emits a 7-bit frame, LSB first, whose first
//   <count> bits are 1 and the rest 0. It builds a parallel copy of the
//   emitted bits and pulses done when the frame is complete.
//
// Optional feature (macro ONES_SEQ_GEN_CHECK_EN):
//   When defined, an internal counter tallies the 1-bits that were actually
//   handshaked. In DONE it is compared with the latched count, and any
//   difference sets the sticky err flag. When undefined, err is tied to 0.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_valid   in   request count offered
//   in_count   in   [2:0] number of ones to emit
//   in_ready   out  request accepted this cycle (high only in IDLE)
//   bit_ready  in   downstream consumes bit_out this cycle
//   bit_valid  out  bit_out carries a frame bit (high only in SEND)
//   bit_out    out  serial frame bit
//   out_word   out  [6:0] parallel image; bit i = i-th emitted bit
//   done       out  one-cycle pulse while in DONE
//   err        out  sticky self-check error flag
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Valid never depends combinationally on ready. Once raised,
// bit_valid and bit_out hold steady until the bit is consumed.
//
// All outputs are registers or decodes of registered state only (Moore).
// The FSM state is visible for debug as the internal signal 'state'.

module ones_seq_gen #(
  parameter int FRAME_LEN = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [2:0]           in_count,
  output logic                 in_ready,
  input  logic                 bit_ready,
  output logic                 bit_valid,
  output logic                 bit_out,
  output logic [FRAME_LEN-1:0] out_word,
  output logic                 done,
  output logic                 err
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  logic [2:0] cnt;
  logic       accept;
  logic       hs;

  assign accept = (state == IDLE) && in_valid;
  assign hs     = (state == SEND) && bit_ready;

  // Moore decodes
  assign in_ready  = (state == IDLE);
  assign bit_valid = (state == SEND);
  assign done      = (state == DONE);
  // Thermometer code: bit positions below the latched count are ones.
  assign bit_out   = (state == SEND) && (idx < cnt);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = SEND;
      SEND: if (bit_ready && (idx == LAST_IDX)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latched count, bit index and parallel image.
  // out_word is cleared only on acceptance so it keeps the last frame
  // through DONE and IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      idx      <= '0;
      out_word <= '0;
    end else if (accept) begin
      cnt      <= in_count;
      idx      <= '0;
      out_word <= '0;
    end else if (hs) begin
      out_word[idx] <= bit_out;
      idx           <= idx + 3'd1;
    end
  end

`ifdef ONES_SEQ_GEN_CHECK_EN
  logic [2:0] ones_cnt;

  // Counts 1-bits that were actually consumed. Seven ones fit in 3 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ones_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        ones_cnt <= '0;
      end else if (hs && bit_out) begin
        ones_cnt <= ones_cnt + 3'd1;
      end
      if ((state == DONE) && (ones_cnt != cnt)) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ones_seq_gen.sv
// Testbench for ones_seq_gen.
// A small reference model decides when a request is accepted. At acceptance
// it pushes the expected frame bits (exp_q) and the expected parallel word
// (word_q). The tick task pops and compares these as the DUT consumes bits
// and pulses done.

module tb_ones_seq_gen;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [2:0] in_count;
  logic       in_ready;
  logic       bit_ready;
  logic       bit_valid;
  logic       bit_out;
  logic [6:0] out_word;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  ones_seq_gen #(.FRAME_LEN(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .in_ready  (in_ready),
    .bit_ready (bit_ready),
    .bit_valid (bit_valid),
    .bit_out   (bit_out),
    .out_word  (out_word),
    .done      (done),
    .err       (err)
  );

  // ---------------- scoreboard / model ----------------
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [0:0] exp_q[$];
  logic [6:0] word_q[$];
  int         m_st     = 0;   // 0 idle, 1 send, 2 done
  int         m_idx    = 0;
  int         m_stall  = 0;
  logic [6:0] m_word   = '0;
  logic       m_err    = 1'b0;
  bit         acc_pending = 1'b0;
  int         acc_edge  = 0;
  int         prev_acc  = 0;
  int         n_done    = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle. Outputs are sampled at the falling edge using the
  // inputs already applied; the model then advances and the rising edge
  // is taken.
  task automatic tick();
    logic [7:0] w;
    @(negedge clk);
    chk1("in_ready",  in_ready,  m_st == 0);
    chk1("bit_valid", bit_valid, m_st == 1);
    chk1("done",      done,      m_st == 2);
    chk1("err",       err,       m_err);
    chk7("out_word",  out_word,  m_word);
    if (m_st == 1) begin
      if (exp_q.size() == 0) begin
        chki("exp_q_underflow", 0, 1);
      end else begin
        chk1("bit_out", bit_out, exp_q[0]);
        if (bit_ready) begin
          m_word[m_idx] = exp_q[0];
          void'(exp_q.pop_front());
          m_idx++;
        end else begin
          m_stall++;
        end
      end
    end else if (m_st == 2) begin
      n_done++;
      if (word_q.size() == 0) chki("word_q_underflow", 0, 1);
      else chk7("frame_word", out_word, word_q.pop_front());
      chki("done_latency", cyc - acc_edge, 7 + m_stall);
    end
    case (m_st)
      0: if (in_valid) begin
        acc_pending = 1'b1;
        m_st    = 1;
        m_idx   = 0;
        m_word  = '0;
        m_stall = 0;
        for (int i = 0; i < 7; i++) exp_q.push_back(1'(i < int'(in_count)));
        w = (8'd1 << in_count) - 8'd1;
        word_q.push_back(w[6:0]);
      end
      1: if (m_idx == 7) m_st = 2;
      default: m_st = 0;
    endcase
    @(posedge clk);
    cyc++;
    if (acc_pending) begin
      prev_acc    = acc_edge;
      acc_edge    = cyc;
      acc_pending = 1'b0;
    end
    #1;
  endtask

  // Ticks until the next done pulse. A timeout counts as a failure.
  task automatic wait_done(input int budget);
    int start;
    start = n_done;
    for (int i = 0; i < budget && n_done == start; i++) tick();
    chki("frame_completed", n_done, start + 1);
  endtask

  task automatic async_reset_pulse();
    reset = 1'b0;
    #2;
    chk1("rst_bit_valid", bit_valid, 1'b0);
    chk1("rst_in_ready",  in_ready,  1'b1);
    chk1("rst_done",      done,      1'b0);
    chk1("rst_bit_out",   bit_out,   1'b0);
    chk1("rst_err",       err,       1'b0);
    chk7("rst_out_word",  out_word,  7'd0);
    m_st = 0; m_idx = 0; m_word = '0; m_err = 1'b0; m_stall = 0;
    exp_q.delete();
    word_q.delete();
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int saved_done;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_count  = 3'd0;
    bit_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_in_ready",  in_ready,  1'b1);
    chk1("reset_bit_valid", bit_valid, 1'b0);
    chk1("reset_done",      done,      1'b0);
    chk1("reset_err",       err,       1'b0);
    chk7("reset_out_word",  out_word,  7'd0);
    reset = 1'b1;
    tick();

    // count 3, bit_ready high: 1,1,1,0,0,0,0 and done 7 edges after accept
    in_valid = 1'b1; in_count = 3'd3;
    tick();
    in_valid = 1'b0;
    wait_done(30);
    tick();
    chk7("word_cnt3", out_word, 7'b0000111);

    // count 0 then 7, in_valid held; in_count changes during SEND are ignored
    in_valid = 1'b1; in_count = 3'd0;
    tick();
    in_count = 3'd7;
    wait_done(30);
    chk7("word_cnt0", out_word, 7'b0000000);
    tick();
    tick();
    chki("b2b_accept_gap", acc_edge - prev_acc, 9);
    in_valid = 1'b0;
    wait_done(30);
    tick();
    chk7("word_cnt7", out_word, 7'b1111111);

    // count 5 with a 4-cycle stall after the 2nd bit
    in_valid = 1'b1; in_count = 3'd5;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    bit_ready = 1'b0;
    repeat (4) tick();
    chk1("stall_bit_out", bit_out, 1'b1);
    chk7("stall_word", out_word, 7'b0000011);
    bit_ready = 1'b1;
    wait_done(30);
    tick();
    chk7("word_cnt5", out_word, 7'b0011111);

    // request pulsed during SEND of a count-6 frame is ignored
    in_valid = 1'b1; in_count = 3'd6;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_count = 3'd2;
    tick();
    in_valid = 1'b0;
    wait_done(30);
    repeat (3) tick();
    chk7("word_cnt6", out_word, 7'b0111111);

    // reset after 3 bits of a count-4 frame
    in_valid = 1'b1; in_count = 3'd4;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    saved_done = n_done;
    async_reset_pulse();
    repeat (10) tick();
    chki("no_done_after_abort", n_done, saved_done);

    // every count with random downstream stalls
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_count = 3'(c);
      bit_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      saved_done = n_done;
      for (int i = 0; i < 80 && n_done == saved_done; i++) begin
        bit_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      chki("rand_frame_completed", n_done, saved_done + 1);
      bit_ready = 1'b1;
    end
    tick();

`ifdef ONES_SEQ_GEN_CHECK_EN
    // corrupt the internal 1-bit tally: err must rise and stick until reset
    in_valid = 1'b1; in_count = 3'd5;
    tick();
    in_valid = 1'b0;
    tick();
    force dut.ones_cnt = 3'd0;
    wait_done(30);
    release dut.ones_cnt;
    m_err = 1'b1;
    repeat (3) tick();
    in_valid = 1'b1; in_count = 3'd1;
    tick();
    in_valid = 1'b0;
    wait_done(30);
    tick();
    chk1("err_sticky", err, 1'b1);
    async_reset_pulse();
    tick();
    chk1("err_cleared", err, 1'b0);
`endif

    chki("exp_q_drained", exp_q.size(), 0);
    chki("word_q_drained", word_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time guard
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
